// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the reset NOP and the RV32 field positions.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4,
        FAULT = 3'd5
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one ready/valid request per start pulse, latched
// into an instruction register with pre-sliced RV32 fields for decode.
//
// Memory handshake: a request transfers in the cycle where imem_req and
// imem_ready are both high; imem_addr is held stable while imem_req waits.
// Exactly one response (imem_rvalid) is expected per accepted request.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  i_addr,
    input  logic         fetch_start,
    input  logic         flush,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_valid,
    output logic [6:0]   opcode,
    output logic [4:0]   rd,
    output logic [2:0]   funct3,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [6:0]   funct7,
    output logic         misaligned,
    output logic         timeout,
    output logic         busy,
    output fetch_state_t dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    fetch_state_t  state, state_n;
    logic [TW-1:0] timer;

    logic start_ok, addr_aligned, load_instr, clr_valid;
    logic timer_clr, timer_inc, set_timeout;

    assign addr_aligned = (i_addr[1:0] == 2'b00);

    always_comb begin
        state_n     = state;
        start_ok    = 1'b0;
        load_instr  = 1'b0;
        clr_valid   = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE, DONE, FAULT: begin
                // A flush here only matters in DONE; any same-cycle start is dropped.
                if (flush) begin
                    if (state == DONE) begin
                        clr_valid = 1'b1;
                        state_n   = IDLE;
                    end
                end else if (fetch_start) begin
                    start_ok = 1'b1;
                    state_n  = addr_aligned ? REQ : FAULT;
                end
            end
            REQ: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (imem_ready) begin
                    state_n   = WAIT;
                    timer_clr = 1'b1;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_n = DRAIN;
                end else if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_n    = DONE;
                end else if (timer >= TIMER_LAST) begin
                    set_timeout = 1'b1;
                    state_n     = FAULT;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            DRAIN: begin
                // The outstanding response still owns the bus; expiry is silent.
                if (imem_rvalid || timer >= TIMER_LAST) begin
                    state_n = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            imem_addr   <= '0;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state <= state_n;
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + TW'(1);
            end
            if (start_ok) begin
                instr_valid <= 1'b0;
                misaligned  <= ~addr_aligned;
                timeout     <= 1'b0;
                if (addr_aligned) begin
                    imem_addr <= i_addr;
                end
            end
            if (clr_valid) begin
                instr_valid <= 1'b0;
            end
            if (load_instr) begin
                instr       <= imem_rdata;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

    assign imem_req  = (state == REQ);
    assign busy      = (state == REQ) || (state == WAIT) || (state == DRAIN);
    assign dbg_state = state;

    assign opcode = instr[OPCODE_LSB +: 7];
    assign rd     = instr[RD_LSB     +: 5];
    assign funct3 = instr[FUNCT3_LSB +: 3];
    assign rs1    = instr[RS1_LSB    +: 5];
    assign rs2    = instr[RS2_LSB    +: 5];
    assign funct7 = instr[FUNCT7_LSB +: 7];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetches with decoded-field
// expectations, followed by hand-written flush/timeout/reset sequences.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int TIMEOUT = 8;

    logic         clk;
    logic         reset;
    logic [31:0]  i_addr;
    logic         fetch_start;
    logic         flush;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic         instr_valid;
    logic [6:0]   opcode;
    logic [4:0]   rd;
    logic [2:0]   funct3;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [6:0]   funct7;
    logic         misaligned;
    logic         timeout;
    logic         busy;
    fetch_state_t dbg_state;

    fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .i_addr(i_addr), .fetch_start(fetch_start),
        .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .misaligned(misaligned), .timeout(timeout),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          rdly;
        int          vdly;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full fetch with a given number of imem_ready and imem_rvalid delay cycles.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int rdly, input int vdly);
        int req_cycles;
        logic [31:0] exp_instr;
        req_cycles = 0;
        exp_q.push_back(data);
        i_addr      = addr;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("start_clears_valid", {31'd0, instr_valid}, 32'd0);
        check("req_addr", imem_addr, addr);
        for (int k = 0; k < rdly; k++) begin
            if (imem_req) req_cycles++;
            step();
        end
        if (imem_req) req_cycles++;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        check("req_cycles", 32'(req_cycles), 32'(rdly + 1));
        for (int k = 0; k < vdly; k++) step();
        check("valid_early", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        check("valid_done", {31'd0, instr_valid}, 32'd1);
        exp_instr = exp_q.pop_front();
        check("instr", instr, exp_instr);
        check("instr_pc", instr_pc, addr);
    endtask

    task automatic start_to_wait(input logic [31:0] addr);
        i_addr      = addr;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        imem_ready  = 1'b1;
        step();
        imem_ready  = 1'b0;
    endtask

    logic [31:0] held;
    int waited;

    initial begin
        reset = 1'b1; i_addr = '0; fetch_start = 1'b0; flush = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        step();
        step();
        reset = 1'b0;

        // reset state
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_opcode", 32'(opcode), 32'h13);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_flags", {29'd0, misaligned, timeout, busy}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // table-driven fetches with decoded-field expectations
        vecs[0] = '{32'h0000_0010, 32'h0050_0093, 0, 0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00};
        vecs[1] = '{32'h0000_0024, 32'h0020_81B3, 1, 0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00};
        vecs[2] = '{32'h0000_0100, 32'h4031_5233, 0, 2, 7'h33, 5'd4, 3'd5, 5'd2, 5'd3, 7'h20};
        vecs[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 2, 1, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F};
        for (int v = 0; v < 4; v++) begin
            do_fetch(vecs[v].addr, vecs[v].data, vecs[v].rdly, vecs[v].vdly);
            check("opcode", 32'(opcode), 32'(vecs[v].op));
            check("rd", 32'(rd), 32'(vecs[v].rd));
            check("funct3", 32'(funct3), 32'(vecs[v].f3));
            check("rs1", 32'(rs1), 32'(vecs[v].rs1));
            check("rs2", 32'(rs2), 32'(vecs[v].rs2));
            check("funct7", 32'(funct7), 32'(vecs[v].f7));
        end

        // flush in DONE clears valid, keeps the word
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("done_flush_valid", {31'd0, instr_valid}, 32'd0);
        check("done_flush_instr", instr, 32'hFFFF_FFFF);
        check("done_flush_state", 32'(dbg_state), 32'(IDLE));

        // misaligned address
        i_addr = 32'h0000_0006; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        check("mis_no_req", {31'd0, imem_req}, 32'd0);
        check("mis_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        check("mis_sticky", {30'd0, misaligned, imem_req}, 32'd2);
        i_addr = 32'h0000_0008; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("mis_cleared", {31'd0, misaligned}, 32'd0);
        check("mis_next_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0;
        check("mis_next_pc", instr_pc, 32'h0000_0008);

        // flush in REQ
        i_addr = 32'h0000_0014; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("req_flush", {30'd0, imem_req, busy}, 32'd0);

        // start and flush together: start dropped
        i_addr = 32'h0000_0018; fetch_start = 1'b1; flush = 1'b1;
        step();
        fetch_start = 1'b0; flush = 1'b0;
        check("start_flush", {30'd0, imem_req, busy}, 32'd0);

        // ready stall of 2 cycles, then no response
        i_addr = 32'h0000_0030; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        waited = 0;
        for (int k = 0; k < 3; k++) begin
            if (imem_req) waited++;
            imem_ready = (k == 2);
            step();
        end
        imem_ready = 1'b0;
        check("stall_req_cycles", 32'(waited), 32'd3);
        check("stall_in_wait", 32'(dbg_state), 32'(WAIT));
        for (int k = 0; k < 7; k++) step();
        check("timeout_not_yet", {31'd0, timeout}, 32'd0);
        step();
        check("timeout_set", {31'd0, timeout}, 32'd1);
        check("timeout_idle_bus", {30'd0, busy, imem_req}, 32'd0);
        step();
        step();
        check("timeout_sticky", {31'd0, timeout}, 32'd1);

        // flush in WAIT, late word is drained
        held = instr;
        start_to_wait(32'h0000_0050);
        check("fault_restart_clears", {31'd0, timeout}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("drain_busy", {31'd0, busy}, 32'd1);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("drain_instr", instr, held);
        check("drain_valid", {31'd0, instr_valid}, 32'd0);
        check("drain_done", {31'd0, busy}, 32'd0);
        do_fetch(32'h0000_0020, 32'h00A0_0113, 0, 0);

        // flush beats rvalid in the same cycle
        start_to_wait(32'h0000_0028);
        flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        flush = 1'b0; imem_rvalid = 1'b0;
        check("flush_rvalid_instr", instr, 32'h00A0_0113);
        check("flush_rvalid_state", 32'(dbg_state), 32'(DRAIN));
        imem_rvalid = 1'b1; imem_rdata = 32'h8765_4321;
        step();
        imem_rvalid = 1'b0;
        check("flush_rvalid_end", {30'd0, busy, instr_valid}, 32'd0);
        check("flush_rvalid_kept", instr, 32'h00A0_0113);

        // start ignored while in WAIT
        start_to_wait(32'h0000_0060);
        i_addr = 32'h0000_0040; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("busy_start_addr", imem_addr, 32'h0000_0060);
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
        step();
        imem_rvalid = 1'b0;
        check("busy_start_pc", instr_pc, 32'h0000_0060);
        check("busy_start_valid", {31'd0, instr_valid}, 32'd1);

        // drain with no response ends silently
        start_to_wait(32'h0000_0034);
        flush = 1'b1;
        step();
        flush = 1'b0;
        waited = 0;
        while (busy && waited < 20) begin
            step();
            waited++;
        end
        check("drain_expire_idle", {31'd0, busy}, 32'd0);
        check("drain_expire_silent", {31'd0, timeout}, 32'd0);

        // reset in WAIT, late response ignored
        start_to_wait(32'h0000_0070);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("wait_reset_state", 32'(dbg_state), 32'(IDLE));
        check("wait_reset_instr", instr, 32'h0000_0013);
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_5555;
        step();
        imem_rvalid = 1'b0;
        check("late_rvalid_instr", instr, 32'h0000_0013);
        check("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
